// File: rtl/led_blink_pkg.sv
// Shared types and defaults for the LED blink controller and its helpers.
package led_blink_pkg;

    localparam int DEF_DIV_W = 4;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SOLID = 2'd1,
        ST_BLINK = 2'd2,
        ST_BURST = 2'd3
    } state_e;

    // A running burst cannot be pre-empted by a new command.
    function automatic logic state_ready(input state_e s);
        return (s != ST_BURST);
    endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Half-period timebase: counts 0..period_i and ticks on the last count, then wraps.
module blink_prescaler #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == period_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_blink_ctrl.sv
// Command-driven LED sequencer: off, solid on, continuous blink, or counted burst.
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             led,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic             led_q, led_d;
    logic             done_q, done_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic             accept;
    logic             presc_clr;
    logic             presc_en;
    logic             tick;

    assign cmd_ready = state_ready(state_q);
    assign busy      = (state_q != ST_IDLE);
    assign led       = led_q;
    assign done      = done_q;
    assign accept    = cmd_valid && cmd_ready;
    assign presc_en  = (state_q == ST_BLINK) || (state_q == ST_BURST);

    blink_prescaler #(
        .DIV_W(DIV_W)
    ) u_presc (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (presc_clr),
        .en_i    (presc_en),
        .period_i(period_q),
        .tick_o  (tick)
    );

    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        done_d    = 1'b0;
        period_d  = period_q;
        count_d   = count_q;
        pulse_d   = pulse_q;
        presc_clr = 1'b0;
        if (accept) begin
            period_d  = cmd_period;
            count_d   = cmd_count;
            pulse_d   = '0;
            presc_clr = 1'b1;
            case (mode_e'(cmd_mode))
                MODE_OFF: begin
                    state_d = ST_IDLE;
                    led_d   = 1'b0;
                end
                MODE_ON: begin
                    state_d = ST_SOLID;
                    led_d   = 1'b1;
                end
                MODE_BLINK: begin
                    state_d = ST_BLINK;
                    led_d   = 1'b1;
                end
                MODE_BURST: begin
                    // A zero-length burst completes immediately.
                    if (cmd_count != '0) begin
                        state_d = ST_BURST;
                        led_d   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        led_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            endcase
        end else begin
            case (state_q)
                ST_BLINK: begin
                    if (tick) begin
                        led_d = ~led_q;
                    end
                end
                ST_BURST: begin
                    if (tick) begin
                        if (led_q) begin
                            led_d   = 1'b0;
                            pulse_d = pulse_q + CNT_W'(1);
                        end else if (pulse_q == count_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            led_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            led_q    <= 1'b0;
            done_q   <= 1'b0;
            period_q <= '0;
            count_q  <= '0;
            pulse_q  <= '0;
        end else begin
            state_q  <= state_d;
            led_q    <= led_d;
            done_q   <= done_d;
            period_q <= period_d;
            count_q  <= count_d;
            pulse_q  <= pulse_d;
        end
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl with a cycle-count reference model checked every cycle.
module tb_led_blink_ctrl;

    localparam int DIV_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [DIV_W-1:0] cmd_period;
    logic [CNT_W-1:0] cmd_count;
    logic             led;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Reference model: mode 0 idle, 1 solid, 2 blink, 3 burst; m_t = cycles since entry.
    int m_mode = 0;
    int m_t    = 0;
    int m_P    = 0;
    int m_N    = 0;
    bit m_done = 1'b0;

    led_blink_ctrl #(
        .DIV_W(DIV_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_period(cmd_period),
        .cmd_count (cmd_count),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic logic model_led();
        if (m_mode == 1) return 1'b1;
        if (m_mode >= 2) return ((m_t / (m_P + 1)) % 2) == 0;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0;
            m_t    = 0;
            m_P    = 0;
            m_N    = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (cmd_valid && m_mode != 3) begin
                m_P = int'(cmd_period);
                m_N = int'(cmd_count);
                m_t = 0;
                case (cmd_mode)
                    2'd0: m_mode = 0;
                    2'd1: m_mode = 1;
                    2'd2: m_mode = 2;
                    default: begin
                        if (cmd_count == '0) begin
                            m_mode = 0;
                            m_done = 1'b1;
                        end else begin
                            m_mode = 3;
                        end
                    end
                endcase
            end else if (m_mode >= 2) begin
                m_t++;
                if (m_mode == 3 && m_t == 2 * m_N * (m_P + 1)) begin
                    m_mode = 0;
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_led",   led,       model_led());
            check("model_busy",  busy,      m_mode != 0);
            check("model_ready", cmd_ready, m_mode != 3);
            check("model_done",  done,      m_done);
        end
    end

    task automatic send(input logic [1:0] mode, input int period, input int count);
        cmd_valid  = 1'b1;
        cmd_mode   = mode;
        cmd_period = DIV_W'(period);
        cmd_count  = CNT_W'(count);
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:15] blink_pat;
        logic [0:3]  fast_pat;
        logic [0:11] burst_pat;
        blink_pat = 16'b1111_0000_1111_0000;
        fast_pat  = 4'b1010;
        burst_pat = 12'b1100_1100_1100;

        rst        = 1'b1;
        cmd_valid  = 1'b1;
        cmd_mode   = 2'd1;
        cmd_period = '0;
        cmd_count  = '0;
        @(negedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_led",   led,       1'b0);
        check("rst_busy",  busy,      1'b0);
        check("rst_done",  done,      1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("post_rst_led", led, 1'b0);

        // ON then OFF
        send(2'd1, 0, 0);
        check("on_led",  led,  1'b1);
        check("on_busy", busy, 1'b1);
        @(negedge clk);
        send(2'd0, 0, 0);
        check("off_led",  led,  1'b0);
        check("off_busy", busy, 1'b0);

        // BLINK P=3, then restart mid-phase with P=0
        send(2'd2, 3, 0);
        for (int i = 0; i < 16; i++) begin
            check("blink3_led", led, blink_pat[i]);
            @(negedge clk);
        end
        repeat (26) @(negedge clk);
        send(2'd2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("blink0_led", led, fast_pat[i]);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);

        // BURST N=3 P=1 with ignored commands during it
        send(2'd3, 1, 3);
        for (int i = 0; i < 12; i++) begin
            check("burst_led",   led,       burst_pat[i]);
            check("burst_ready", cmd_ready, 1'b0);
            check("burst_done",  done,      1'b0);
            cmd_valid = (i >= 2 && i < 8);
            cmd_mode  = 2'd1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("burst_end_done",  done,      1'b1);
        check("burst_end_led",   led,       1'b0);
        check("burst_end_busy",  busy,      1'b0);
        check("burst_end_ready", cmd_ready, 1'b1);
        @(negedge clk);
        check("burst_after_done", done, 1'b0);

        // BURST N=0
        send(2'd3, 2, 0);
        check("burst0_done", done, 1'b1);
        check("burst0_led",  led,  1'b0);
        check("burst0_busy", busy, 1'b0);
        @(negedge clk);
        check("burst0_after_done", done, 1'b0);

        // Reset mid-BURST
        send(2'd3, 1, 5);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_led",   led,       1'b0);
        check("abort_busy",  busy,      1'b0);
        check("abort_done",  done,      1'b0);
        check("abort_ready", cmd_ready, 1'b1);
        repeat (4) @(negedge clk);

        // Boundary widths: longest burst at P=0, slowest blink
        send(2'd3, 0, 15);
        repeat (34) @(negedge clk);
        send(2'd2, 15, 0);
        repeat (40) @(negedge clk);
        send(2'd1, 0, 0);
        check("blink_to_on_led", led, 1'b1);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
